keccak_perm_arbiter: RTL and testbench

- Time-shares one Keccak-f[1600] permutation core among N_REQ requesters, e.g. the matrix-A XOF, the noise PRF and the H/G hash engines.
- Arbitration is round-robin. The block latches the granted requester's 1600-bit state and launches one permutation.
- It waits for the core's valid, captures the result, and returns it with a per-requester done pulse.
- A watchdog aborts a permutation that never completes.

---
 rtl/keccak_pkg.sv | 29 ++
 rtl/keccak_rr_pick.sv | 39 +++
 rtl/keccak_perm_arbiter.sv | 116 +++++++++++
 tb/tb_keccak_perm_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak permutation arbiter: state width,
// FSM encoding and a width helper for counters and indices.
package keccak_pkg;

    localparam int KECCAK_BW = 1600;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LAUNCH = ST_LAUNCH,
        WAIT   = ST_WAIT,
        DONE   = ST_DONE
    } state_t;

    // Number of bits needed to hold values 0..v-1 (ceil(log2(v))).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_rr_pick.sv
// Rotating-priority picker: the first set request after ptr wins, scanning
// ptr+1, ptr+2, ... modulo N_REQ. Purely combinational.
module keccak_rr_pick
    import keccak_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic [PW-1:0]    idx
);

    // One spare bit so ptr+i cannot overflow before the modulo fold.
    localparam logic [PW:0] NQ = (PW+1)'(N_REQ);

    // Walk the candidates in priority order and keep the first hit.
    always_comb begin
        logic [PW:0] k;
        logic        found;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = {1'b0, ptr} + (PW+1)'(i);
            if (k >= NQ) begin
                k = k - NQ;
            end
            if (!found && req[k[PW-1:0]]) begin
                found             = 1'b1;
                win[k[PW-1:0]]    = 1'b1;
                idx               = k[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/keccak_perm_arbiter.sv
// Time-shares one Keccak-f[1600] permutation core among N_REQ requesters.
// Round-robin grant, one launch strobe per job, result capture on the core's
// valid, per-requester done pulse, and a watchdog that aborts a stuck job.
module keccak_perm_arbiter
    import keccak_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int BW_DATA = KECCAK_BW,
    parameter int TIMEOUT = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*BW_DATA-1:0] i_req_state,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [N_REQ-1:0]         o_done,
    output logic [BW_DATA-1:0]       o_state,
    output logic                     o_err,
    output logic                     o_busy,
    output logic [BW_DATA-1:0]       o_perm_state,
    output logic                     o_perm_valid,
    input  logic [BW_DATA-1:0]       i_perm_state,
    input  logic                     i_perm_valid
);

    localparam int PW = clog2(N_REQ);
    localparam int CW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt_idx;
    logic [CW-1:0]      cnt;
    logic [N_REQ-1:0]   pick_win;
    logic [PW-1:0]      pick_idx;
    logic [BW_DATA-1:0] sel_state;

    keccak_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (i_req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx)
    );

    // One-hot mux of the winning requester's state slice.
    always_comb begin
        sel_state = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_win[k]) begin
                sel_state = sel_state | i_req_state[k*BW_DATA +: BW_DATA];
            end
        end
    end

    assign o_busy = (state != IDLE);

    // Arbitration FSM, watchdog counter and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            ptr          <= PW'(N_REQ - 1);
            gnt_idx      <= '0;
            cnt          <= '0;
            o_gnt        <= '0;
            o_done       <= '0;
            o_err        <= 1'b0;
            o_state      <= '0;
            o_perm_state <= '0;
            o_perm_valid <= 1'b0;
        end else begin
            // Strobes are high for a single cycle unless re-asserted below.
            o_perm_valid <= 1'b0;
            o_done       <= '0;
            o_err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        gnt_idx      <= pick_idx;
                        o_gnt        <= pick_win;
                        o_perm_state <= sel_state;
                        o_perm_valid <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the final watchdog cycle still wins.
                    if (i_perm_valid) begin
                        o_state <= i_perm_state;
                        o_done  <= o_gnt;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        o_err  <= 1'b1;
                        o_done <= o_gnt;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    ptr   <= gnt_idx;
                    o_gnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Scoreboard bench for keccak_perm_arbiter with a latency-programmable
// permutation core stub.
module tb_keccak_perm_arbiter;

    localparam int N  = 3;
    localparam int BW = 1600;
    localparam int TO = 64;

    typedef struct {
        logic [N-1:0]  done;
        logic          err;
        logic [BW-1:0] state;
    } exp_t;

    logic            clk;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [N*BW-1:0] i_req_state;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_done;
    logic [BW-1:0]   o_state;
    logic            o_err;
    logic            o_busy;
    logic [BW-1:0]   o_perm_state;
    logic            o_perm_valid;
    logic [BW-1:0]   i_perm_state;
    logic            i_perm_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    exp_t sb[$];
    int   done_q[$];
    int   launch_cyc;
    logic [N-1:0] launch_gnt;
    int   n_launch = 0;
    int   n_done   = 0;

    int            stub_lat = 24;
    bit            stub_on  = 1'b1;
    int            stub_cnt = 0;
    logic [BW-1:0] stub_data;
    bit            auto_drop = 1'b1;
    bit            rereq0    = 1'b0;

    logic [BW-1:0] st [N];

    keccak_perm_arbiter #(
        .N_REQ   (N),
        .BW_DATA (BW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_req_state  (i_req_state),
        .o_gnt        (o_gnt),
        .o_done       (o_done),
        .o_state      (o_state),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_perm_state (o_perm_state),
        .o_perm_valid (o_perm_valid),
        .i_perm_state (i_perm_state),
        .i_perm_valid (i_perm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference permutation of the core stub.
    function automatic logic [BW-1:0] stub_f(input logic [BW-1:0] x);
        return {x[BW-2:0], x[BW-1]} ^ {(BW/32){32'hA5C3_0F96}};
    endfunction

    function automatic logic [BW-1:0] rnd_state();
        logic [BW-1:0] v;
        for (int w = 0; w < BW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (low 128 bits)", tag, got[127:0], exp[127:0]);
    endtask

    task automatic push_exp(input int k, input bit err, input logic [BW-1:0] s);
        exp_t e;
        e.done  = N'(1 << k);
        e.err   = err;
        e.state = s;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge; monitor outputs, then drive the stub.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (o_perm_valid) begin
            n_launch++;
            launch_cyc = cyc;
            launch_gnt = o_gnt;
        end
        if (o_done != '0) begin
            n_done++;
            done_q.push_back(cyc);
            if (sb.size() == 0) begin
                check_val("unexpected_done", BW'(o_done), BW'(0));
            end else begin
                e = sb.pop_front();
                check_val("done_vec", BW'(o_done), BW'(e.done));
                check_val("done_err", BW'(o_err), BW'(e.err));
                check_val("done_state", o_state, e.state);
            end
            if (auto_drop) i_req = i_req & ~o_done;
            if (rereq0 && o_done[0]) begin
                i_req[0] = 1'b1;
                rereq0   = 1'b0;
            end
        end
        i_perm_valid = 1'b0;
        if (i_rst) stub_cnt = 0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && stub_on) begin
                i_perm_valid = 1'b1;
                i_perm_state = stub_data;
            end
        end
        if (o_perm_valid && !i_rst) begin
            stub_cnt  = stub_lat;
            stub_data = stub_f(o_perm_state);
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (sb.size() == 0 && !o_busy && i_req == '0) break;
        end
        check_val({tag, "_drain"}, BW'(sb.size()), BW'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_gnt"}, BW'(o_gnt), BW'(0));
        check_val({tag, "_done"}, BW'(o_done), BW'(0));
        check_val({tag, "_state"}, o_state, BW'(0));
        check_val({tag, "_err"}, BW'(o_err), BW'(0));
        check_val({tag, "_busy"}, BW'(o_busy), BW'(0));
        check_val({tag, "_pstate"}, o_perm_state, BW'(0));
        check_val({tag, "_pvalid"}, BW'(o_perm_valid), BW'(0));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_req = '0;
        step();
        step();
        i_rst = 1'b0;
    endtask

    initial begin
        int t0;
        int nl;
        int nd;
        logic [BW-1:0] keep;
        i_rst        = 1'b1;
        i_req        = '0;
        i_perm_valid = 1'b0;
        i_perm_state = '0;
        for (int k = 0; k < N; k++) begin
            st[k] = rnd_state();
            i_req_state[k*BW +: BW] = st[k];
        end
        step();
        step();
        step();
        check_all_zero("reset");
        i_rst = 1'b0;
        step();

        // Single request from requester 1, core latency 24.
        stub_lat = 24;
        nl = n_launch;
        push_exp(1, 1'b0, stub_f(st[1]));
        done_q.delete();
        t0 = cyc;
        i_req = 3'b010;
        step();
        step();
        step();
        i_req_state[1*BW +: BW] = rnd_state();
        run_until_idle("single", 200);
        check_val("single_launch_lat", BW'(launch_cyc - t0), BW'(1));
        check_val("single_launch_gnt", BW'(launch_gnt), BW'(3'b010));
        check_val("single_launch_cnt", BW'(n_launch - nl), BW'(1));
        check_val("single_done_lat", BW'(done_q[0] - t0), BW'(26));
        i_req_state[1*BW +: BW] = st[1];

        // All three requesters at once from reset: served 0, 1, 2.
        do_reset();
        done_q.delete();
        push_exp(0, 1'b0, stub_f(st[0]));
        push_exp(1, 1'b0, stub_f(st[1]));
        push_exp(2, 1'b0, stub_f(st[2]));
        i_req = 3'b111;
        run_until_idle("all3", 400);
        check_val("all3_ndone", BW'(done_q.size()), BW'(3));
        check_val("all3_gap01", BW'(done_q[1] - done_q[0]), BW'(27));
        check_val("all3_gap12", BW'(done_q[2] - done_q[1]), BW'(27));

        // Requester 0 re-requests at its done while 2 waits: 2 goes first.
        push_exp(0, 1'b0, stub_f(st[0]));
        push_exp(2, 1'b0, stub_f(st[2]));
        push_exp(0, 1'b0, stub_f(st[0]));
        rereq0 = 1'b1;
        i_req  = 3'b101;
        run_until_idle("fair", 400);

        // Watchdog: core never answers.
        stub_on = 1'b0;
        keep = stub_f(st[0]);
        done_q.delete();
        push_exp(1, 1'b1, keep);
        i_req = 3'b010;
        run_until_idle("wdog", 200);
        check_val("wdog_lat", BW'(done_q[0] - launch_cyc), BW'(TO + 1));
        check_val("wdog_idle_next", BW'(cyc - done_q[0]), BW'(1));
        check_val("wdog_gnt_clr", BW'(o_gnt), BW'(0));
        check_val("wdog_state_kept", o_state, keep);

        // Valid arrives on the very last watchdog cycle: result wins.
        stub_on  = 1'b1;
        stub_lat = TO;
        done_q.delete();
        push_exp(2, 1'b0, stub_f(st[2]));
        i_req = 3'b100;
        run_until_idle("edge", 200);
        check_val("edge_lat", BW'(done_q[0] - launch_cyc), BW'(TO + 1));

        // Reset in the middle of a wait: job vanishes without done.
        stub_lat = 24;
        nd = n_done;
        i_req = 3'b001;
        for (int i = 0; i < 12; i++) step();
        check_val("mid_busy", BW'(o_busy), BW'(1));
        i_rst = 1'b1;
        i_req = '0;
        step();
        check_all_zero("midrst");
        i_rst = 1'b0;
        for (int i = 0; i < 40; i++) step();
        i_perm_valid = 1'b1;
        i_perm_state = rnd_state();
        step();
        step();
        check_val("stray_state", o_state, BW'(0));
        check_val("midrst_no_done", BW'(n_done - nd), BW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
